// File: rtl/cdb_arbiter_if.sv
// Common data bus bundle: requester-side request/result lines, consumer stall,
// the combinational grant and the registered broadcast outputs.
//
// Handshake: a requester raises req[i] with req_tag/req_data slice i and keeps all
// three stable until it sees grant[i] high at a rising edge; req[i] && grant[i] at
// that edge is the transfer. grant never asserts while cdb_hold is high. The accepted
// result appears on cdb_valid/cdb_tag/cdb_data for exactly the following cycle.
interface cdb_arbiter_if #(
  parameter int N_REQ     = 4,
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8
);
  logic [N_REQ-1:0]           req;
  logic [N_REQ*UNIT_SIZE-1:0] req_tag;
  logic [N_REQ*WORD_SIZE-1:0] req_data;
  logic                       cdb_hold;
  logic [N_REQ-1:0]           grant;
  logic                       cdb_valid;
  logic [UNIT_SIZE-1:0]       cdb_tag;
  logic [WORD_SIZE-1:0]       cdb_data;
  logic [15:0]                bcast_cnt;

  // Requester/consumer side.
  modport master (
    output req, req_tag, req_data, cdb_hold,
    input  grant, cdb_valid, cdb_tag, cdb_data, bcast_cnt
  );

  // Arbiter side.
  modport slave (
    input  req, req_tag, req_data, cdb_hold,
    output grant, cdb_valid, cdb_tag, cdb_data, bcast_cnt
  );
endinterface

// File: rtl/cdb_arbiter.sv
// Round-robin arbiter and single driver for the common data bus. One request is
// granted per cycle starting from the rotating priority pointer; the winner's tag and
// result are broadcast on registered outputs in the next cycle.
module cdb_arbiter #(
  parameter int N_REQ     = 4,
  parameter int WORD_SIZE = 32,
  parameter int UNIT_SIZE = 8
) (
  input  logic         clk,
  input  logic         rst,
  cdb_arbiter_if.slave bus
);
  localparam int PTR_W = $clog2(N_REQ);

  logic [PTR_W-1:0]     ptr;
  logic [PTR_W-1:0]     idx;
  logic [PTR_W-1:0]     win;
  logic                 found;
  logic                 granted;
  logic [N_REQ-1:0]     grant_c;
  logic [UNIT_SIZE-1:0] sel_tag;
  logic [WORD_SIZE-1:0] sel_data;

  logic                 cdb_valid_q;
  logic [UNIT_SIZE-1:0] cdb_tag_q;
  logic [WORD_SIZE-1:0] cdb_data_q;
  logic [15:0]          bcast_cnt_q;

  // Scan requests from ptr upward with wrap; the first one found wins unless stalled or in reset.
  always_comb begin
    found = 1'b0;
    win   = '0;
    idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      idx = ptr + PTR_W'(k);
      if (!found && bus.req[idx]) begin
        found = 1'b1;
        win   = idx;
      end
    end
    granted = found && !rst && !bus.cdb_hold;
  end

  // One-hot grant vector and the winner's tag/data mux.
  always_comb begin
    grant_c  = '0;
    sel_tag  = '0;
    sel_data = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (granted && (win == PTR_W'(i))) begin
        grant_c[i] = 1'b1;
        sel_tag    = bus.req_tag[i*UNIT_SIZE +: UNIT_SIZE];
        sel_data   = bus.req_data[i*WORD_SIZE +: WORD_SIZE];
      end
    end
  end

  // Broadcast registers, rotating pointer and saturating broadcast counter.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      ptr         <= '0;
      cdb_valid_q <= 1'b0;
      cdb_tag_q   <= '0;
      cdb_data_q  <= '0;
      bcast_cnt_q <= '0;
    end else if (granted) begin
      ptr         <= win + PTR_W'(1);
      cdb_valid_q <= 1'b1;
      cdb_tag_q   <= sel_tag;
      cdb_data_q  <= sel_data;
      if (bcast_cnt_q != 16'hFFFF) bcast_cnt_q <= bcast_cnt_q + 16'd1;
    end else begin
      // Idle or stalled: tag/data keep their last broadcast values.
      cdb_valid_q <= 1'b0;
    end
  end

  assign bus.grant     = grant_c;
  assign bus.cdb_valid = cdb_valid_q;
  assign bus.cdb_tag   = cdb_tag_q;
  assign bus.cdb_data  = cdb_data_q;
  assign bus.bcast_cnt = bcast_cnt_q;
endmodule

// File: tb/tb_cdb_arbiter.sv
// Bench for cdb_arbiter (N_REQ=4): directed scenarios with literal expectations,
// a randomized requester phase and a saturation run, all continuously compared
// against a distance-based round-robin model and a broadcast queue.
module tb_cdb_arbiter;
  localparam int N  = 4;
  localparam int WS = 32;
  localparam int US = 8;

  logic clk;
  logic rst;

  cdb_arbiter_if #(.N_REQ(N), .WORD_SIZE(WS), .UNIT_SIZE(US)) bus ();

  cdb_arbiter #(.N_REQ(N), .WORD_SIZE(WS), .UNIT_SIZE(US)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // ---------------- behavioural model ----------------
  int                  ptr_m = 0;
  logic                valid_m = 1'b0;
  logic [US-1:0]       tag_m = '0;
  logic [WS-1:0]       data_m = '0;
  int                  cnt_m = 0;
  logic [US+WS-1:0]    exp_q[$];

  // Winner is the requesting index with the smallest forward distance from ptr.
  function automatic int exp_winner(logic [N-1:0] r, logic h, logic rs, int p);
    int best;
    int bd;
    int d;
    best = -1;
    bd   = N;
    if (rs || h) return -1;
    for (int i = 0; i < N; i++) begin
      if (r[i]) begin
        d = (i - p + N) % N;
        if (d < bd) begin
          bd   = d;
          best = i;
        end
      end
    end
    return best;
  endfunction

  function automatic logic [N-1:0] exp_grant(int w);
    logic [N-1:0] g;
    g = '0;
    if (w >= 0) g[w] = 1'b1;
    return g;
  endfunction

  always @(posedge clk or posedge rst) begin : model
    int w;
    if (rst) begin
      ptr_m   <= 0;
      valid_m <= 1'b0;
      tag_m   <= '0;
      data_m  <= '0;
      cnt_m   <= 0;
      exp_q.delete();
    end else begin
      w = exp_winner(bus.req, bus.cdb_hold, rst, ptr_m);
      if (w >= 0) begin
        valid_m <= 1'b1;
        tag_m   <= bus.req_tag[w*US +: US];
        data_m  <= bus.req_data[w*WS +: WS];
        exp_q.push_back({bus.req_tag[w*US +: US], bus.req_data[w*WS +: WS]});
        ptr_m   <= (w + 1) % N;
        if (cnt_m < 65535) cnt_m <= cnt_m + 1;
      end else begin
        valid_m <= 1'b0;
      end
    end
  end

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard compare (every falling edge) ----------------
  always @(negedge clk) begin : compare
    logic [US+WS-1:0] e;
    chk("grant", 64'(bus.grant), 64'(exp_grant(exp_winner(bus.req, bus.cdb_hold, rst, ptr_m))));
    chk("cdb_valid", 64'(bus.cdb_valid), 64'(valid_m));
    chk("cdb_tag", 64'(bus.cdb_tag), 64'(tag_m));
    chk("cdb_data", 64'(bus.cdb_data), 64'(data_m));
    chk("bcast_cnt", 64'(bus.bcast_cnt), 64'(cnt_m));
    if (valid_m) begin
      if (exp_q.size() == 0) begin
        chk("exp_q_empty", 64'(1), 64'(0));
      end else begin
        e = exp_q.pop_front();
        chk("bcast_word", 64'({bus.cdb_tag, bus.cdb_data}), 64'(e));
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_slot(input int i, input logic [US-1:0] t, input logic [WS-1:0] d);
    bus.req_tag[i*US +: US]  = t;
    bus.req_data[i*WS +: WS] = d;
  endtask

  // ---------------- stimulus ----------------
  initial begin : driver
    int w;
    rst          = 1'b1;
    bus.req      = 4'b1111;
    bus.cdb_hold = 1'b0;
    bus.req_tag  = '0;
    bus.req_data = '0;
    for (int i = 0; i < N; i++) set_slot(i, US'(8'h10 + i), WS'(32'hA000_0000 + i));

    // Reset with all requests raised.
    tick();
    tick();
    chk("rst_grant", 64'(bus.grant), 64'(0));
    chk("rst_valid", 64'(bus.cdb_valid), 64'(0));
    chk("rst_tag", 64'(bus.cdb_tag), 64'(0));
    chk("rst_data", 64'(bus.cdb_data), 64'(0));
    chk("rst_cnt", 64'(bus.bcast_cnt), 64'(0));
    rst = 1'b0;
    #1;
    chk("first_grant", 64'(bus.grant), 64'(4'b0001));
    tick();
    bus.req = 4'b0000;
    tick();

    // Single request on slot 2.
    set_slot(2, 8'h22, 32'hDEADBEEF);
    bus.req = 4'b0100;
    #1;
    chk("single_grant", 64'(bus.grant), 64'(4'b0100));
    tick();
    bus.req = 4'b0000;
    chk("single_valid", 64'(bus.cdb_valid), 64'(1));
    chk("single_tag", 64'(bus.cdb_tag), 64'(8'h22));
    chk("single_data", 64'(bus.cdb_data), 64'(32'hDEADBEEF));
    tick();
    chk("single_idle", 64'(bus.cdb_valid), 64'(0));

    // Pointer after win: ptr is 3 now.
    bus.req = 4'b1000;
    #1;
    chk("ptr_grant3", 64'(bus.grant), 64'(4'b1000));
    tick();
    bus.req = 4'b1001;
    #1;
    chk("ptr_wrap0", 64'(bus.grant), 64'(4'b0001));
    tick();
    bus.req = 4'b1000;
    #1;
    chk("ptr_then3", 64'(bus.grant), 64'(4'b1000));
    tick();
    bus.req = 4'b0000;
    set_slot(2, 8'h12, 32'hA000_0002);

    // Round robin, all requesting for 8 cycles (ptr is 0 here).
    bus.req = 4'b1111;
    for (int c = 0; c < 8; c++) begin
      #1;
      chk("rr_grant", 64'(bus.grant), 64'(4'b0001 << (c % 4)));
      tick();
      chk("rr_valid", 64'(bus.cdb_valid), 64'(1));
      chk("rr_tag", 64'(bus.cdb_tag), 64'(8'h10 + (c % 4)));
    end

    // Hold with two requesters.
    bus.req      = 4'b0011;
    bus.cdb_hold = 1'b1;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("hold_grant", 64'(bus.grant), 64'(0));
      tick();
      chk("hold_valid", 64'(bus.cdb_valid), 64'(0));
    end
    bus.cdb_hold = 1'b0;
    #1;
    chk("unhold_g0", 64'(bus.grant), 64'(4'b0001));
    tick();
    chk("unhold_tag0", 64'(bus.cdb_tag), 64'(8'h10));
    bus.req = 4'b0010;
    #1;
    chk("unhold_g1", 64'(bus.grant), 64'(4'b0010));
    tick();
    chk("unhold_tag1", 64'(bus.cdb_tag), 64'(8'h11));
    bus.req = 4'b0000;
    tick();

    // Async reset in the middle of a stream.
    bus.req = 4'b1111;
    tick();
    tick();
    chk("pre_rst_valid", 64'(bus.cdb_valid), 64'(1));
    #3;
    rst = 1'b1;
    #2;
    chk("async_valid", 64'(bus.cdb_valid), 64'(0));
    chk("async_grant", 64'(bus.grant), 64'(0));
    #1;
    rst = 1'b0;
    #1;
    chk("post_rst_grant", 64'(bus.grant), 64'(4'b0001));
    tick();
    chk("post_rst_tag", 64'(bus.cdb_tag), 64'(8'h10));
    bus.req = 4'b0000;
    tick();

    // Randomized requesters: drop after acceptance, occasional withdrawal, random hold.
    for (int c = 0; c < 3000; c++) begin
      bus.cdb_hold = ($urandom_range(0, 4) == 0);
      w = exp_winner(bus.req, bus.cdb_hold, rst, ptr_m);
      tick();
      for (int i = 0; i < N; i++) begin
        if (i == w || (bus.req[i] && $urandom_range(0, 15) == 0)) begin
          bus.req[i] = 1'b0;
        end
        if (!bus.req[i] && $urandom_range(0, 2) == 0) begin
          bus.req[i] = 1'b1;
          set_slot(i, US'($urandom_range(0, 255)), WS'($urandom()));
        end
      end
    end

    // Saturation: continuous grants.
    bus.cdb_hold = 1'b0;
    bus.req      = 4'b1111;
    for (int c = 0; c < 65540; c++) tick();
    chk("sat_cnt", 64'(bus.bcast_cnt), 64'(16'hFFFF));
    bus.req = 4'b0000;
    tick();
    tick();
    chk("sat_hold_cnt", 64'(bus.bcast_cnt), 64'(16'hFFFF));

    // ---------------- final report ----------------
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
